regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 47 ++++
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester encoding for the register-file writeback arbiter.
// Imported by the top level and by the round-robin arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned NUM_REQ  = 2;

    // Requester index encoding, also the value held by the round-robin pointer
    localparam logic IDX_ALU = 1'b0;
    localparam logic IDX_LSU = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_ALU  = 2'b01,
        GNT_LSU  = 2'b10
    } grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, and a tie goes to
// the requester that was not granted last. The pointer moves only on a transfer.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic   r_last_grant;
    grant_e w_grant;

    always_comb begin
        w_grant = GNT_NONE;
        unique case (req)
            2'b01:   w_grant = GNT_ALU;
            2'b10:   w_grant = GNT_LSU;
            2'b11: begin
                if (r_last_grant == IDX_ALU) begin
                    w_grant = GNT_LSU;
                end else begin
                    w_grant = GNT_ALU;
                end
            end
            default: w_grant = GNT_NONE;
        endcase
    end

    assign grant = w_grant;

    // Pointer resets to LSU so the first tie after reset goes to the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDX_LSU;
        end else if (advance && (w_grant != GNT_NONE)) begin
            if (w_grant == GNT_LSU) begin
                r_last_grant <= IDX_LSU;
            end else begin
                r_last_grant <= IDX_ALU;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit results into one register-file
// write port through a single draining stage, with source-pending reporting.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd_addr,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,

    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd_addr,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,

    input  logic            flush,

    output logic            we,
    output logic [AW-1:0]   rd_addr,
    output logic [XLEN-1:0] rd_din,

    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic            rs1_pending,
    output logic            rs2_pending
);

    logic [1:0]      w_req;
    logic [1:0]      w_grant;
    logic            w_alu_xfer;
    logic            w_lsu_xfer;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_addr;
    logic [XLEN-1:0] w_sel_data;
    logic            w_stg_live;

    logic            r_stg_valid;
    logic [AW-1:0]   r_stg_addr;
    logic [XLEN-1:0] r_stg_data;

    assign w_req = {lsu_valid, alu_valid};

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    // Ready never depends on stage occupancy; it is only suppressed in reset
    assign alu_ready  = w_grant[IDX_ALU] & ~rst;
    assign lsu_ready  = w_grant[IDX_LSU] & ~rst;
    assign w_alu_xfer = alu_valid & alu_ready;
    assign w_lsu_xfer = lsu_valid & lsu_ready;
    assign w_xfer     = w_alu_xfer | w_lsu_xfer;

    always_comb begin
        w_sel_addr = alu_rd_addr;
        w_sel_data = alu_data;
        if (w_lsu_xfer) begin
            w_sel_addr = lsu_rd_addr;
            w_sel_data = lsu_data;
        end
    end

    // Stage holds a write for exactly one cycle; a new transfer beats flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
            r_stg_addr  <= '0;
            r_stg_data  <= '0;
        end else if (w_xfer) begin
            r_stg_valid <= 1'b1;
            r_stg_addr  <= w_sel_addr;
            r_stg_data  <= w_sel_data;
        end else begin
            r_stg_valid <= 1'b0;
            if (flush) begin
                r_stg_addr <= '0;
                r_stg_data <= '0;
            end
        end
    end

    assign we      = r_stg_valid & (r_stg_addr != '0);
    assign rd_addr = r_stg_addr;
    assign rd_din  = r_stg_data;

    // In reset the stage is about to be discarded, so only requests count
    assign w_stg_live = r_stg_valid & ~rst;

    function automatic logic src_pending(
        input logic [AW-1:0] rs,
        input logic          stg_v,
        input logic [AW-1:0] stg_a,
        input logic          alu_v,
        input logic [AW-1:0] alu_a,
        input logic          lsu_v,
        input logic [AW-1:0] lsu_a
    );
        logic hit;
        hit = (stg_v && (rs == stg_a)) ||
              (alu_v && (rs == alu_a)) ||
              (lsu_v && (rs == lsu_a));
        return (rs != '0) && hit;
    endfunction

    assign rs1_pending = src_pending(rs1_addr, w_stg_live, r_stg_addr,
                                     alu_valid, alu_rd_addr,
                                     lsu_valid, lsu_rd_addr);
    assign rs2_pending = src_pending(rs2_addr, w_stg_live, r_stg_addr,
                                     alu_valid, alu_rd_addr,
                                     lsu_valid, lsu_rd_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single requests, ties,
// x0 writes, same-rd collisions, flush and mid-operation reset.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd_addr;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd_addr;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            flush;
    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_din;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic            rs1_pending;
    logic            rs2_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd_addr (alu_rd_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd_addr (lsu_rd_addr),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .flush       (flush),
        .we          (we),
        .rd_addr     (rd_addr),
        .rd_din      (rd_din),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [XLEN-1:0] ld);
        alu_valid   = av;
        alu_rd_addr = aa;
        alu_data    = ad;
        lsu_valid   = lv;
        lsu_rd_addr = la;
        lsu_data    = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Grants must be mutually exclusive in every cycle
    always @(negedge clk) begin
        check("ready_onehot", 32'(alu_ready & lsu_ready), 32'h0);
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        rs1_addr = 5'd4;
        rs2_addr = 5'd0;
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'h0);
        tick();
        tick();

        // Reset state: no grants, no write, pending from valid inputs only
        check("rst_alu_ready", 32'(alu_ready), 32'h0);
        check("rst_lsu_ready", 32'(lsu_ready), 32'h0);
        check("rst_we", 32'(we), 32'h0);
        check("rst_rs1_pending", 32'(rs1_pending), 32'h1);
        check("rst_rs2_pending_x0", 32'(rs2_pending), 32'h0);

        rst      = 1'b0;
        rs1_addr = 5'd0;
        idle();
        tick();
        check("post_rst_we", 32'(we), 32'h0);
        tick();
        tick();

        // Sustained tie: ALU, LSU, ALU, LSU with a write every cycle
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("tie_alu_ready", 32'(alu_ready), ((i % 2) == 0) ? 32'h1 : 32'h0);
            check("tie_lsu_ready", 32'(lsu_ready), ((i % 2) == 1) ? 32'h1 : 32'h0);
            tick();
            check("tie_we", 32'(we), 32'h1);
            check("tie_rd_addr", 32'(rd_addr), ((i % 2) == 0) ? 32'd3 : 32'd7);
            check("tie_rd_din", rd_din, ((i % 2) == 0) ? 32'h33 : 32'h77);
        end
        idle();
        tick();
        check("tie_drain_we", 32'(we), 32'h0);

        // Lone ALU request, one-cycle write latency
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
        #1;
        check("alu_only_ready", 32'(alu_ready), 32'h1);
        check("alu_only_lsu_ready", 32'(lsu_ready), 32'h0);
        tick();
        idle();
        check("alu_only_we", 32'(we), 32'h1);
        check("alu_only_rd_addr", 32'(rd_addr), 32'd5);
        check("alu_only_rd_din", rd_din, 32'hDEAD_BEEF);
        tick();
        check("alu_only_drain_we", 32'(we), 32'h0);

        // Load to x0 is accepted but never written
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        #1;
        check("x0_lsu_ready", 32'(lsu_ready), 32'h1);
        check("x0_rs1_pending", 32'(rs1_pending), 32'h0);
        tick();
        idle();
        check("x0_we", 32'(we), 32'h0);
        tick();

        // Same rd from both: ALU first (pointer at LSU), LSU value lands last
        rs1_addr = 5'd9;
        rs2_addr = 5'd10;
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        #1;
        check("same_rd_alu_ready", 32'(alu_ready), 32'h1);
        check("same_rd_lsu_ready", 32'(lsu_ready), 32'h0);
        check("same_rd_rs1_pending0", 32'(rs1_pending), 32'h1);
        check("same_rd_rs2_pending", 32'(rs2_pending), 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h2);
        #1;
        check("same_rd_we1", 32'(we), 32'h1);
        check("same_rd_addr1", 32'(rd_addr), 32'd9);
        check("same_rd_din1", rd_din, 32'h1);
        check("same_rd_lsu_ready2", 32'(lsu_ready), 32'h1);
        check("same_rd_rs1_pending1", 32'(rs1_pending), 32'h1);
        tick();
        idle();
        #1;
        check("same_rd_we2", 32'(we), 32'h1);
        check("same_rd_addr2", 32'(rd_addr), 32'd9);
        check("same_rd_din2", rd_din, 32'h2);
        check("same_rd_rs1_pending2", 32'(rs1_pending), 32'h1);
        tick();
        check("same_rd_we_done", 32'(we), 32'h0);
        check("same_rd_rs1_pending_done", 32'(rs1_pending), 32'h0);
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;

        // Flush the cycle after a transfer, no new request
        drive(1'b1, 5'd12, 32'hAA, 1'b0, 5'd0, 32'h0);
        #1;
        check("flush_alu_ready", 32'(alu_ready), 32'h1);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_we", 32'(we), 32'h0);

        // Flush together with a transfer: the new write still issues
        flush = 1'b1;
        drive(1'b1, 5'd13, 32'hBB, 1'b0, 5'd0, 32'h0);
        #1;
        check("flush_xfer_ready", 32'(alu_ready), 32'h1);
        tick();
        flush = 1'b0;
        idle();
        check("flush_xfer_we", 32'(we), 32'h1);
        check("flush_xfer_rd_addr", 32'(rd_addr), 32'd13);
        check("flush_xfer_rd_din", rd_din, 32'hBB);
        tick();

        // Flush with a staged write and a new transfer back to back
        drive(1'b1, 5'd14, 32'hCC, 1'b0, 5'd0, 32'h0);
        tick();
        flush = 1'b1;
        drive(1'b1, 5'd15, 32'hDD, 1'b0, 5'd0, 32'h0);
        tick();
        flush = 1'b0;
        idle();
        check("flush_b2b_we", 32'(we), 32'h1);
        check("flush_b2b_rd_addr", 32'(rd_addr), 32'd15);
        check("flush_b2b_rd_din", rd_din, 32'hDD);
        tick();

        // Reset while the stage holds a write
        drive(1'b1, 5'd20, 32'h55, 1'b0, 5'd0, 32'h0);
        tick();
        idle();
        rst      = 1'b1;
        rs1_addr = 5'd20;
        #1;
        check("mid_rst_rs1_pending", 32'(rs1_pending), 32'h0);
        tick();
        check("mid_rst_we", 32'(we), 32'h0);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
        #1;
        check("mid_rst_alu_ready", 32'(alu_ready), 32'h0);
        check("mid_rst_lsu_ready", 32'(lsu_ready), 32'h0);
        tick();
        check("mid_rst_we2", 32'(we), 32'h0);
        rst      = 1'b0;
        rs1_addr = 5'd0;
        #1;
        check("after_rst_we", 32'(we), 32'h0);
        check("after_rst_alu_ready", 32'(alu_ready), 32'h1);
        check("after_rst_lsu_ready", 32'(lsu_ready), 32'h0);
        tick();
        idle();
        check("after_rst_first_we", 32'(we), 32'h1);
        check("after_rst_first_addr", 32'(rd_addr), 32'd3);
        check("after_rst_first_din", rd_din, 32'h33);
        tick();
        check("after_rst_drain_we", 32'(we), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
